// File: rtl/ex_divider.sv
// Iterative 32-bit divider for the EX stage: DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional DIV_EARLY_EN: finish in one cycle when |dividend| < |divisor|.
module ex_divider (
  input  logic        s_clk_i,
  input  logic        s_rst_i,
  input  logic        s_start_i,
  input  logic [31:0] s_op1_i,
  input  logic [31:0] s_op2_i,
  input  logic [1:0]  s_f_i,
  input  logic        s_flush_i,
  input  logic        s_stall_i,
  output logic        s_busy_o,
  output logic        s_done_o,
  output logic [31:0] s_result_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] rem_q, quo_q, dvs_q;
  logic        rem_sel, neg_q, neg_r;

  logic        accept, is_signed, a_neg, b_neg, div_zero, ovf, early, special;
  logic [31:0] a_abs, b_abs, spec_q, spec_r, spec_res;
  logic [32:0] shifted, diff;
  logic [31:0] rem_nxt, quo_nxt, calc_res;

  always_comb begin
    is_signed = ~s_f_i[0];
    a_neg     = is_signed & s_op1_i[31];
    b_neg     = is_signed & s_op2_i[31];
    a_abs     = a_neg ? (~s_op1_i + 32'd1) : s_op1_i;
    b_abs     = b_neg ? (~s_op2_i + 32'd1) : s_op2_i;
    div_zero  = (s_op2_i == 32'd0);
    ovf       = is_signed & (s_op1_i == 32'h8000_0000) & (s_op2_i == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_EN
    early     = ~div_zero & (a_abs < b_abs);
`else
    early     = 1'b0;
`endif
    special   = div_zero | ovf | early;
    accept    = (state == IDLE) & s_start_i & ~s_flush_i;
  end

  // Result for the operations that bypass the iterative loop.
  always_comb begin
    spec_q = 32'hFFFF_FFFF;
    spec_r = s_op1_i;
    if (ovf) begin
      spec_q = 32'h8000_0000;
      spec_r = 32'd0;
    end else if (early) begin
      spec_q = 32'd0;
      spec_r = s_op1_i;
    end
    spec_res = s_f_i[1] ? spec_r : spec_q;
  end

  // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    if (!diff[32]) begin
      rem_nxt = diff[31:0];
      quo_nxt = {quo_q[30:0], 1'b1};
    end else begin
      rem_nxt = shifted[31:0];
      quo_nxt = {quo_q[30:0], 1'b0};
    end
    if (rem_sel) calc_res = neg_r ? (~rem_nxt + 32'd1) : rem_nxt;
    else         calc_res = neg_q ? (~quo_nxt + 32'd1) : quo_nxt;
  end

  always_ff @(posedge s_clk_i or posedge s_rst_i) begin
    if (s_rst_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : CALC;
      CALC:    if (cnt == 5'd0) state_nxt = DONE;
      DONE:    if (!s_stall_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (s_flush_i) state_nxt = IDLE;
  end

  always_ff @(posedge s_clk_i or posedge s_rst_i) begin
    if (s_rst_i) begin
      cnt        <= 5'd0;
      rem_q      <= 32'd0;
      quo_q      <= 32'd0;
      dvs_q      <= 32'd0;
      rem_sel    <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      s_result_o <= 32'd0;
    end else if (accept) begin
      cnt     <= 5'd31;
      rem_q   <= 32'd0;
      quo_q   <= a_abs;
      dvs_q   <= b_abs;
      rem_sel <= s_f_i[1];
      neg_q   <= a_neg ^ b_neg;
      neg_r   <= a_neg;
      if (special) s_result_o <= spec_res;
    end else if (state == CALC && !s_flush_i) begin
      cnt   <= cnt - 5'd1;
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      if (cnt == 5'd0) s_result_o <= calc_res;
    end
  end

  assign s_done_o = (state == DONE);
  assign s_busy_o = (state == CALC) | ((state == DONE) & s_stall_i);

endmodule

// File: tb/tb_ex_divider.sv
// Self-checking bench for ex_divider: directed literal cases plus randomized traffic
// checked every cycle against an arithmetic reference model.
module tb_ex_divider;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op1 = '0, op2 = '0;
  logic [1:0]  f = '0;
  logic        flush = 1'b0, stall = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  ex_divider dut (
    .s_clk_i(clk), .s_rst_i(rst), .s_start_i(start), .s_op1_i(op1), .s_op2_i(op2),
    .s_f_i(f), .s_flush_i(flush), .s_stall_i(stall),
    .s_busy_o(busy), .s_done_o(done), .s_result_o(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_val(input logic [1:0] fs, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!fs[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (fs[0]) begin
      q = a / b; r = a % b;
    end else begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end
    return fs[1] ? r : q;
  endfunction

  function automatic int ref_lat(input logic [1:0] fs, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_EN
    longint sa, sb;
`endif
    if (b == 32'd0) return 1;
    if (!fs[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_EN
    sa = fs[0] ? longint'(a) : longint'($signed(a));
    sb = fs[0] ? longint'(b) : longint'($signed(b));
    if (sa < 0) sa = -sa;
    if (sb < 0) sb = -sb;
    if (sa < sb) return 1;
`endif
    return 33;
  endfunction

  // Reference model: 0 idle, 1 computing, 2 result presented.
  int          m_phase = 0;
  int          m_left = 0;
  logic [31:0] m_res = '0, m_pend = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_left = 0; m_res = '0;
    end else if (flush) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
             m_pend = ref_val(f, op1, op2);
             if (ref_lat(f, op1, op2) == 1) begin
               m_phase = 2; m_res = m_pend;
             end else begin
               m_phase = 1; m_left = 32;
             end
           end
        1: begin
             m_left--;
             if (m_left == 0) begin m_phase = 2; m_res = m_pend; end
           end
        default: if (!stall) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("model_done", {31'd0, done}, {31'd0, m_phase == 2});
    check("model_busy", {31'd0, busy}, {31'd0, (m_phase == 1) || (m_phase == 2 && stall)});
    check("model_result", result, m_res);
  end

  // Called at #1 after a posedge with the DUT idle; returns the same way.
  task automatic run_op(input string name, input logic [1:0] fs, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int explat);
    int n = 0;
    bit seen = 0;
    f = fs; op1 = a; op2 = b; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk); n++;
      if (done) seen = 1;
    end
    check({name, "_latency"}, n, explat);
    check({name, "_result"}, result, exp);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_op1();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return $urandom_range(0, 20);
      2: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rnd_op2();
    case ($urandom_range(0, 9))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return $urandom_range(1, 15);
      3: return -$urandom_range(1, 15);
      4: return $urandom_range(16, 5000);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit seen;
`ifdef DIV_EARLY_EN
    int lat_small = 1;
`else
    int lat_small = 33;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;

    run_op("div_100_7",   2'b00, 32'd100,        32'd7,          32'd14,         33);
    run_op("rem_100_7",   2'b10, 32'd100,        32'd7,          32'd2,          33);
    run_op("divu_by0",    2'b01, 32'h1234,       32'd0,          32'hFFFF_FFFF,  1);
    run_op("remu_by0",    2'b11, 32'h1234,       32'd0,          32'h1234,       1);
    run_op("div_ovf",     2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
    run_op("rem_ovf",     2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1);
    run_op("divu_3_10",   2'b01, 32'd3,          32'd10,         32'd0,          lat_small);
    run_op("div_m7_2",    2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33);
    run_op("rem_m7_2",    2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33);
    run_op("divu_m7_2",   2'b01, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  33);

    // Flush in the 10th computing cycle.
    f = 2'b01; op1 = 32'hFFFF_FFFF; op2 = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_result", result, 32'h7FFF_FFFC);
    run_op("after_flush", 2'b00, 32'd100, 32'd7, 32'd14, 33);

    // Stall held for three result cycles.
    stall = 1'b1;
    f = 2'b00; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk); n++;
      if (done) seen = 1;
    end
    check("stall_latency", n, 33);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_done", {31'd0, done}, 32'd1);
      check("stall_busy", {31'd0, busy}, 32'd1);
      check("stall_result", result, 32'd14);
    end
    #1 stall = 1'b0;
    @(posedge clk); #1;
    check("stall_release_done", {31'd0, done}, 32'd0);
    check("stall_release_busy", {31'd0, busy}, 32'd0);
    check("stall_release_result", result, 32'd14);

    // Reset pulse in the middle of a computation.
    f = 2'b01; op1 = 32'hFFFF_FFFF; op2 = 32'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_result", result, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    run_op("after_reset", 2'b00, 32'd100, 32'd7, 32'd14, 33);

    // Random traffic; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 1) == 0);
      f     = 2'($urandom_range(0, 3));
      op1   = rnd_op1();
      op2   = rnd_op2();
      stall = ($urandom_range(0, 9) < 3);
      flush = ($urandom_range(0, 99) < 2);
      @(posedge clk); #1;
    end
    start = 1'b0; stall = 1'b0; flush = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_divider.md
EX_DIVIDER -- requirements
Module: ex_divider

Interface
REQ-001 SHALL provide s_clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-002 SHALL provide s_rst_i, input, 1: asynchronous, active-high reset.
REQ-003 SHALL provide s_start_i, input, 1: start request from the EX stage; the operands are latched when it is accepted.
REQ-004 SHALL provide s_op1_i, input, 32: dividend (operand 1 from the OPEX registers).
REQ-005 SHALL provide s_op2_i, input, 32: divisor (operand 2 from the OPEX registers).
REQ-006 SHALL provide s_f_i, input, 2: operation select; 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL provide s_flush_i, input, 1: flush from the MA stage.
REQ-008 SHALL provide s_stall_i, input, 1: stall from the MA stage; blocks result hand-off.
REQ-009 SHALL provide s_busy_o, output, 1: the EX stage must stall; OP stage holds its registers.
REQ-010 SHALL provide s_done_o, output, 1: s_result_o is valid.
REQ-011 SHALL provide s_result_o, output, 32: quotient or remainder, per the latched s_f_i.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 SHALL accept s_start_i only in IDLE with s_flush_i low, latching operands, s_f_i, signedness and the result signs.
REQ-014 SHALL, for signed ops, divide absolute values using a 32-bit unsigned restoring divider at 1 quotient bit per cycle, then negate the quotient if the operand signs differ and give the remainder the sign of the dividend.
REQ-015 SHALL on acceptance enter CALC with a 5-bit iteration counter set to 31, decrement it each CALC cycle, and enter DONE on the cycle the counter reaches 0 (32 CALC cycles).
REQ-016 SHALL assert s_done_o exactly 33 cycles after the accepting edge for a normal operation.
REQ-017 SHALL treat divisor==0 as a special case: on acceptance go directly to DONE (s_done_o 1 cycle after the accepting edge), quotient 0xFFFFFFFF, remainder = dividend, signed and unsigned.
REQ-018 SHALL treat DIV/REM with 0x80000000 / 0xFFFFFFFF as a special case: direct to DONE, quotient 0x80000000, remainder 0.
REQ-019 SHALL drive s_done_o = (state==DONE).
REQ-020 SHALL drive s_busy_o = CALC | (DONE & s_stall_i).
REQ-021 SHALL in DONE return to IDLE at the first edge with s_stall_i low; otherwise it holds DONE and s_result_o.
REQ-022 SHALL ignore s_start_i in CALC and DONE.
REQ-023 SHALL register s_result_o on entry to DONE and hold it until the next DONE entry.
REQ-024 SHALL on s_flush_i high return to IDLE at the next edge from any state, discarding the result-in-progress without changing s_result_o; flush overrides a simultaneous start.

Reset
REQ-025 SHALL on s_rst_i asynchronously force IDLE, counter 0, all datapath registers 0, s_result_o=0, s_done_o=0, s_busy_o=0, including mid-CALC.
REQ-026 SHALL leave reset synchronously: the first possible acceptance is at the first rising edge after s_rst_i deasserts.

Configuration
REQ-027 SHALL, with DIV_EARLY_EN defined, detect |dividend| < |divisor| (divisor nonzero) on acceptance and go directly to DONE with quotient 0, remainder = dividend (1-cycle latency).
REQ-028 SHALL, with DIV_EARLY_EN undefined, run such operations through the full 32 CALC cycles, giving identical results at 33-cycle latency.

Verification
REQ-029 SHALL test DIV 100,7: s_done_o at +33 with 14; REM 100,7: 2.
REQ-030 SHALL test DIV 0xFFFFFFF9 (-7),2: 0xFFFFFFFD; REM: 0xFFFFFFFF; DIVU 0xFFFFFFF9,2: 0x7FFFFFFC.
REQ-031 SHALL test DIVU 0x1234,0: 0xFFFFFFFF at +1; REMU 0x1234,0: 0x1234; DIV 0x80000000,0xFFFFFFFF: 0x80000000 at +1; REM: 0.
REQ-032 SHALL test start, then s_flush_i at the 10th CALC cycle: IDLE next edge, s_done_o never rises, s_result_o unchanged, new start accepted at once.
REQ-033 SHALL test s_stall_i held 3 cycles during DONE: s_done_o and s_busy_o high for 3 cycles, result stable; IDLE after release.
REQ-034 SHALL test DIVU 3,10 with and without DIV_EARLY_EN: result 0 at +1 and +33 respectively; s_rst_i pulse mid-CALC clears all outputs to 0 immediately.
